// File: rtl/oram_uart_cmd_responder_pkg.sv
// rtl/oram_uart_cmd_responder_pkg.sv - shared widths, opcodes, frontend command codes and FSM states
package oram_uart_cmd_responder_pkg;

    localparam int UART_WIDTH  = 8;
    localparam int OP_WIDTH    = 8;
    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 32;
    localparam int COUNT_WIDTH = 32;
    localparam int FED_WIDTH   = 64;
    localparam int EXEC_WIDTH  = 32;

    localparam logic [OP_WIDTH-1:0] OP_WRITE = 8'h00;
    localparam logic [OP_WIDTH-1:0] OP_READ  = 8'h02;
    localparam logic [OP_WIDTH-1:0] OP_HALT  = 8'hFF;

    localparam logic [1:0] BECMD_UPDATE  = 2'd0;
    localparam logic [1:0] BECMD_APPEND  = 2'd1;
    localparam logic [1:0] BECMD_READ    = 2'd2;
    localparam logic [1:0] BECMD_READRMV = 2'd3;

    typedef enum logic [2:0] {
        ST_RECV,
        ST_DECODE,
        ST_WRITE,
        ST_READ,
        ST_LOAD,
        ST_HALT,
        ST_SEND,
        ST_DELAY
    } state_t;

endpackage

// File: rtl/oram_uart_word_serializer.sv
// rtl/oram_uart_word_serializer.sv - parallel-load word to MSB-first byte stream with valid/ready
module oram_uart_word_serializer #(
    parameter int WordWidth = 64,
    parameter int ByteWidth = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_load,
    input  logic [WordWidth-1:0] i_word,
    output logic [ByteWidth-1:0] o_tx_data,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ready,
    output logic                 o_last
);

    localparam int NBytes = WordWidth / ByteWidth;
    localparam int CntW   = $clog2(NBytes + 1);

    logic [WordWidth-1:0] r_word;
    logic [CntW-1:0]      r_left;
    logic                 w_fire;

    assign o_tx_valid = (r_left != '0);
    assign o_tx_data  = o_tx_valid ? r_word[WordWidth-1 -: ByteWidth] : '0;
    assign w_fire     = o_tx_valid && i_tx_ready;
    assign o_last     = w_fire && (r_left == CntW'(1));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_word <= '0;
            r_left <= '0;
        end else if (i_load) begin
            r_word <= i_word;
            r_left <= CntW'(NBytes);
        end else if (w_fire) begin
            r_word <= r_word << ByteWidth;
            r_left <= r_left - CntW'(1);
        end
    end

endmodule

// File: rtl/oram_uart_cmd_responder.sv
// rtl/oram_uart_cmd_responder.sv - UART packet receiver, ORAM command issuer and response sender
module oram_uart_cmd_responder
    import oram_uart_cmd_responder_pkg::*;
#(
    parameter int UARTWidth  = UART_WIDTH,
    parameter int OpWidth    = OP_WIDTH,
    parameter int AddrWidth  = ADDR_WIDTH,
    parameter int DataWidth  = DATA_WIDTH,
    parameter int CountWidth = COUNT_WIDTH,
    parameter int FEDWidth   = FED_WIDTH
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [UARTWidth-1:0] i_rx_data,
    input  logic                 i_rx_valid,
    output logic                 o_rx_ready,
    output logic [UARTWidth-1:0] o_tx_data,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ready,
    output logic [1:0]           o_cmd,
    output logic [AddrWidth-1:0] o_paddr,
    output logic                 o_cmd_valid,
    input  logic                 i_cmd_ready,
    output logic [FEDWidth-1:0]  o_store_data,
    output logic                 o_store_valid,
    input  logic                 i_store_ready,
    input  logic [FEDWidth-1:0]  i_load_data,
    input  logic                 i_load_valid,
    output logic                 o_load_ready,
    output logic                 o_done
);

    localparam int PktWidth = OpWidth + AddrWidth + DataWidth + CountWidth;
    localparam int PktBytes = PktWidth / UARTWidth;
    localparam int ByteCntW = $clog2(PktBytes);

    state_t                r_state, w_next;
    logic [PktWidth-1:0]   r_pkt;
    logic [ByteCntW-1:0]   r_byte_cnt;
    logic [EXEC_WIDTH-1:0] r_exec;
    logic [CountWidth-1:0] r_delay;
    logic                  r_cmd_done, r_store_done, r_done;

    logic [OpWidth-1:0]    w_op;
    logic [AddrWidth-1:0]  w_addr;
    logic [DataWidth-1:0]  w_data;
    logic [CountWidth-1:0] w_count;
    logic                  w_rx_fire, w_last_byte, w_cmd_fire, w_store_fire;
    logic                  w_cmd_ok, w_store_ok, w_exec_inc;
    logic                  w_ser_load, w_ser_last;
    logic [FEDWidth-1:0]   w_ser_word;

    assign w_op    = r_pkt[PktWidth-1 -: OpWidth];
    assign w_addr  = r_pkt[PktWidth-OpWidth-1 -: AddrWidth];
    assign w_data  = r_pkt[CountWidth +: DataWidth];
    assign w_count = r_pkt[CountWidth-1:0];

    assign o_rx_ready    = (r_state == ST_RECV);
    assign o_cmd_valid   = ((r_state == ST_WRITE) && !r_cmd_done) || (r_state == ST_READ);
    assign o_cmd         = (r_state == ST_READ) ? BECMD_READ : BECMD_UPDATE;
    assign o_paddr       = o_cmd_valid ? w_addr : '0;
    assign o_store_valid = (r_state == ST_WRITE) && !r_store_done;
    assign o_store_data  = o_store_valid ? FEDWidth'(w_data) : '0;
    assign o_load_ready  = (r_state == ST_LOAD);
    assign o_done        = r_done;

    assign w_rx_fire    = o_rx_ready && i_rx_valid;
    assign w_last_byte  = (r_byte_cnt == ByteCntW'(PktBytes - 1));
    assign w_cmd_fire   = o_cmd_valid && i_cmd_ready;
    assign w_store_fire = o_store_valid && i_store_ready;
    assign w_cmd_ok     = r_cmd_done || w_cmd_fire;
    assign w_store_ok   = r_store_done || w_store_fire;

    always_comb begin
        w_next     = r_state;
        w_ser_load = 1'b0;
        w_ser_word = '0;
        w_exec_inc = 1'b0;
        case (r_state)
            ST_RECV:   if (w_rx_fire && w_last_byte) w_next = ST_DECODE;
            ST_DECODE: begin
                if (w_op == OP_WRITE)     w_next = ST_WRITE;
                else if (w_op == OP_READ) w_next = ST_READ;
                else if (w_op == OP_HALT) w_next = ST_HALT;
                else                      w_next = ST_RECV;
            end
            ST_WRITE: begin
                if (w_cmd_ok && w_store_ok) begin
                    w_exec_inc = 1'b1;
                    w_next     = (w_count == '0) ? ST_RECV : ST_DELAY;
                end
            end
            ST_READ:   if (i_cmd_ready) w_next = ST_LOAD;
            ST_LOAD: begin
                if (i_load_valid) begin
                    w_ser_load = 1'b1;
                    w_ser_word = i_load_data;
                    w_exec_inc = 1'b1;
                    w_next     = ST_SEND;
                end
            end
            ST_HALT: begin
                w_ser_load = 1'b1;
                w_ser_word = FEDWidth'(r_exec);
                w_exec_inc = 1'b1;
                w_next     = ST_SEND;
            end
            ST_SEND:   if (w_ser_last) w_next = (w_count == '0) ? ST_RECV : ST_DELAY;
            ST_DELAY:  if (r_delay == CountWidth'(1)) w_next = ST_RECV;
            default:   w_next = ST_RECV;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_RECV;
            r_pkt        <= '0;
            r_byte_cnt   <= '0;
            r_exec       <= '0;
            r_delay      <= '0;
            r_cmd_done   <= 1'b0;
            r_store_done <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_rx_fire) begin
                r_pkt      <= {r_pkt[PktWidth-UARTWidth-1:0], i_rx_data};
                r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + ByteCntW'(1);
            end
            if (r_state == ST_DECODE) begin
                r_cmd_done   <= 1'b0;
                r_store_done <= 1'b0;
            end else if (r_state == ST_WRITE) begin
                if (w_cmd_fire)   r_cmd_done   <= 1'b1;
                if (w_store_fire) r_store_done <= 1'b1;
            end
            // Entry to Delay loads Count; Count=0 never enters, so Delay lasts exactly Count cycles.
            if (w_next == ST_DELAY && r_state != ST_DELAY) r_delay <= w_count;
            else if (r_state == ST_DELAY)                  r_delay <= r_delay - CountWidth'(1);
            if (w_exec_inc)           r_exec <= r_exec + EXEC_WIDTH'(1);
            if (r_state == ST_HALT)   r_done <= 1'b1;
        end
    end

    oram_uart_word_serializer #(
        .WordWidth(FEDWidth),
        .ByteWidth(UARTWidth)
    ) u_serializer (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_load    (w_ser_load),
        .i_word    (w_ser_word),
        .o_tx_data (o_tx_data),
        .o_tx_valid(o_tx_valid),
        .i_tx_ready(i_tx_ready),
        .o_last    (w_ser_last)
    );

endmodule

// File: tb/tb_oram_uart_cmd_responder.sv
// tb/tb_oram_uart_cmd_responder.sv - table-driven bench for the UART command responder
module tb_oram_uart_cmd_responder;
    import oram_uart_cmd_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        tx_toggle = 1'b0;
    logic [1:0]  cmd;
    logic [31:0] paddr;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic [63:0] store_data;
    logic        store_valid;
    logic        store_ready = 1'b1;
    logic [63:0] load_data = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic        done;

    always #5 clk = ~clk;

    oram_uart_cmd_responder dut (
        .i_clock(clk), .i_reset(rst),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
        .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
        .o_cmd(cmd), .o_paddr(paddr), .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready),
        .o_store_data(store_data), .o_store_valid(store_valid), .i_store_ready(store_ready),
        .i_load_data(load_data), .i_load_valid(load_valid), .o_load_ready(load_ready),
        .o_done(done)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out", name);
    endtask

    // Frontend model and handshake monitor, sampled on the falling edge.
    int          cyc = 0;
    int          n_cmd = 0, n_store = 0, t_evt = 0, last_gap = -1;
    logic [1:0]  last_cmd = '0;
    logic [31:0] last_paddr = '0, cur_addr = '0;
    logic [63:0] last_store = '0;
    logic [7:0]  tx_q[$];
    logic [63:0] mem [256] = '{default: '0};
    logic        load_clr = 1'b0;
    logic        p_cv = 0, p_cr = 0, p_sv = 0, p_sr = 0, p_tv = 0, p_tr = 0, p_rx = 0;
    logic [1:0]  p_cmd = '0;
    logic [31:0] p_pa = '0;
    logic [63:0] p_sd = '0;
    logic [7:0]  p_td = '0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        tx_ready = tx_toggle ? ~tx_ready : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (p_cv && !p_cr) begin
                check("cmd_hold_valid", {63'd0, cmd_valid}, 64'd1);
                check("cmd_hold_addr", {30'd0, cmd, paddr}, {30'd0, p_cmd, p_pa});
            end
            if (p_sv && !p_sr) check("store_hold", {store_valid, store_data[62:0]}, {1'b1, p_sd[62:0]});
            if (p_tv && !p_tr) check("tx_hold", {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, p_td});
            if (load_clr) begin
                load_valid = 1'b0;
                load_clr   = 1'b0;
            end
            if (load_valid && load_ready) load_clr = 1'b1;
            if (cmd_valid && cmd_ready) begin
                n_cmd++;
                last_cmd   = cmd;
                last_paddr = paddr;
                t_evt      = cyc;
                if (cmd == BECMD_READ) begin
                    load_data  = mem[paddr[7:0]];
                    load_valid = 1'b1;
                end
            end
            if (store_valid && store_ready) begin
                n_store++;
                last_store = store_data;
                t_evt      = cyc;
                mem[cur_addr[7:0]] = store_data;
            end
            if (tx_valid && tx_ready) begin
                tx_q.push_back(tx_data);
                t_evt = cyc;
            end
            if (rx_ready && !p_rx) last_gap = cyc - t_evt - 1;
        end
        p_cv = cmd_valid;  p_cr = cmd_ready;  p_cmd = cmd;  p_pa = paddr;
        p_sv = store_valid; p_sr = store_ready; p_sd = store_data;
        p_tv = tx_valid;   p_tr = tx_ready;   p_td = tx_data;
        p_rx = rx_ready;
    end

    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!rx_ready) timeout("rx_accept");
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_packet(input logic [7:0] op, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] c, input int nbytes);
        logic [103:0] pkt;
        pkt = {op, a, d, c};
        for (int i = 0; i < nbytes; i++) send_byte(pkt[103-8*i -: 8]);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (rx_ready && k < 5000) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (!rx_ready && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (!rx_ready) timeout("return_to_recv");
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] count;
        int          ncmd;
        logic [1:0]  cmd;
        int          nstore;
        logic [63:0] store;
        int          ntx;
        logic [63:0] word;
        int          gap;
        logic        done;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int c0, s0, q0;
        logic [63:0] w;
        c0 = n_cmd;
        s0 = n_store;
        q0 = tx_q.size();
        cur_addr = v.addr;
        send_packet(v.op, v.addr, v.data, v.count, 13);
        wait_idle();
        check("cmd_count", 64'(n_cmd - c0), 64'(v.ncmd));
        if (v.ncmd > 0) begin
            check("cmd_type", {62'd0, last_cmd}, {62'd0, v.cmd});
            check("paddr", {32'd0, last_paddr}, {32'd0, v.addr});
        end
        check("store_count", 64'(n_store - s0), 64'(v.nstore));
        if (v.nstore > 0) check("store_data", last_store, v.store);
        check("tx_bytes", 64'(tx_q.size() - q0), 64'(v.ntx));
        if (v.ntx == 8 && tx_q.size() - q0 == 8) begin
            w = '0;
            for (int i = 0; i < 8; i++) w = {w[55:0], tx_q[q0+i]};
            check("tx_word", w, v.word);
        end
        if (v.gap >= 0) check("idle_gap", 64'(last_gap), 64'(v.gap));
        check("done", {63'd0, done}, {63'd0, v.done});
    endtask

    vec_t vt[10];

    initial begin
        int c0, s0, k;
        vt[0] = '{OP_WRITE, 32'h38c, 32'h0,        32'd0,   1, BECMD_UPDATE, 1, 64'h0,        0, 64'h0,        0,   1'b0};
        vt[1] = '{OP_WRITE, 32'h3f9, 32'hf,        32'd0,   1, BECMD_UPDATE, 1, 64'hf,        0, 64'h0,        0,   1'b0};
        vt[2] = '{OP_READ,  32'h3f9, 32'h0,        32'd100, 1, BECMD_READ,   0, 64'h0,        8, 64'hf,        100, 1'b0};
        vt[3] = '{OP_WRITE, 32'h010, 32'hdeadbeef, 32'd3,   1, BECMD_UPDATE, 1, 64'hdeadbeef, 0, 64'h0,        3,   1'b0};
        vt[4] = '{OP_HALT,  32'h0,   32'h0,        32'd0,   0, BECMD_UPDATE, 0, 64'h0,        8, 64'h4,        0,   1'b1};
        vt[5] = '{8'h07,    32'h555, 32'h77,       32'd5,   0, BECMD_UPDATE, 0, 64'h0,        0, 64'h0,        -1,  1'b1};
        vt[6] = '{OP_WRITE, 32'h020, 32'h12345678, 32'd0,   1, BECMD_UPDATE, 1, 64'h12345678, 0, 64'h0,        0,   1'b1};
        vt[7] = '{OP_READ,  32'h010, 32'h0,        32'd1,   1, BECMD_READ,   0, 64'h0,        8, 64'hdeadbeef, 1,   1'b1};
        vt[8] = '{OP_HALT,  32'h0,   32'h0,        32'd2,   0, BECMD_UPDATE, 0, 64'h0,        8, 64'h7,        2,   1'b1};
        vt[9] = '{OP_READ,  32'h38c, 32'h0,        32'd0,   1, BECMD_READ,   0, 64'h0,        8, 64'h0,        0,   1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {59'd0, cmd_valid, store_valid, tx_valid, load_ready, done}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_rx_ready", {63'd0, rx_ready}, 64'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) run_vec(vt[i]);

        // Write with StoreReady granted five cycles before CmdReady, TX ready toggling.
        cmd_ready   = 1'b0;
        store_ready = 1'b0;
        tx_toggle   = 1'b1;
        c0 = n_cmd;
        s0 = n_store;
        cur_addr = 32'haa;
        send_packet(OP_WRITE, 32'haa, 32'h55, 32'd0, 13);
        repeat (3) @(posedge clk);
        #1;
        store_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        cmd_ready = 1'b1;
        wait_idle();
        check("bp_cmd_count", 64'(n_cmd - c0), 64'd1);
        check("bp_store_count", 64'(n_store - s0), 64'd1);
        check("bp_paddr", {32'd0, last_paddr}, 64'haa);
        check("bp_store_data", last_store, 64'h55);
        check("bp_gap", 64'(last_gap), 64'd0);

        cmd_ready = 1'b0;
        c0 = n_cmd;
        k  = tx_q.size();
        send_packet(OP_READ, 32'haa, 32'h0, 32'd2, 13);
        repeat (4) @(posedge clk);
        #1;
        cmd_ready = 1'b1;
        wait_idle();
        check("bp_read_cmds", 64'(n_cmd - c0), 64'd1);
        check("bp_tx_bytes", 64'(tx_q.size() - k), 64'd8);
        if (tx_q.size() - k == 8)
            check("bp_tx_word", {tx_q[k], tx_q[k+1], tx_q[k+2], tx_q[k+3],
                                 tx_q[k+4], tx_q[k+5], tx_q[k+6], tx_q[k+7]}, 64'h55);
        check("bp_gap_read", 64'(last_gap), 64'd2);
        tx_toggle = 1'b0;

        // Reset after six bytes of a packet; a fresh packet must start at byte 0.
        send_packet(OP_WRITE, 32'h999, 32'h0, 32'd0, 6);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midreset_outputs", {59'd0, cmd_valid, store_valid, tx_valid, load_ready, done}, 64'd0);
        check("midreset_data", {paddr, store_data[31:0]}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_vec('{OP_WRITE, 32'h123, 32'h99, 32'd0, 1, BECMD_UPDATE, 1, 64'h99, 0, 64'h0, 0, 1'b0});
        run_vec('{OP_HALT,  32'h0,   32'h0,  32'd0, 0, BECMD_UPDATE, 0, 64'h0,  8, 64'h1, 0, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
